data_mem_access_controller: RTL and testbench



---
 rtl/data_mem_access_controller_pkg.sv | 48 ++++
 rtl/data_mem_access_controller_if.sv | 35 +++
 rtl/load_align_extend.sv | 33 +++
 rtl/data_mem_access_controller.sv | 138 +++++++++++++
 tb/tb_data_mem_access_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_access_controller_pkg.sv
// Shared types for the MEM-stage data memory access controller:
// funct3 codes, FSM states, fault causes and the legality check.
package data_mem_access_controller_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_t;

  // Illegal encodings outrank misalignment.
  function automatic cause_t check_access(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ill;
    logic mis;
    ill = rd & wr;
    if (rd & !wr)
      ill = !(f3 inside {LB, LH, LW, LBU, LHU});
    if (wr & !rd)
      ill = !(f3 inside {SB, SH, SW});
    mis = ((f3[1:0] == 2'b01) && a[0])
       || ((f3[1:0] == 2'b10) && (a != 2'b00));
    if (ill) return CAUSE_ILLEGAL;
    if (mis) return CAUSE_MISALIGN;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/data_mem_access_controller_if.sv
// Pipeline request/response and memory req/ack bundle.
// master = controller side, slave = pipeline + memory side.
interface data_mem_access_controller_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  mem_read, mem_write, func3, address, write_data,
    output busy, done, load_data, fault, fault_cause,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output mem_read, mem_write, func3, address, write_data,
    input  busy, done, load_data, fault, fault_cause,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_align_extend.sv
// Picks the byte/half lane of a memory word and extends it.
// rdata_i word, addr_i byte offset, func3_i load type -> data_o.
module load_align_extend
  import data_mem_access_controller_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[7:0];
    unique case (addr_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
    endcase
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (func3_i)
      LB:      data_o = {{24{b[7]}}, b};
      LH:      data_o = {{16{h[15]}}, h};
      LBU:     data_o = {24'd0, b};
      LHU:     data_o = {16'd0, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access_controller.sv
// MEM-stage load/store sequencer: checks, req/ack access, extend.
// Ports: CLK, RESET, bus (pipeline + memory bundle, master side).
module data_mem_access_controller
  import data_mem_access_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input logic CLK,
  input logic RESET,
  data_mem_access_controller_if.master bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  cause_t      cause_q, cause_d;

  logic        req;
  cause_t      chk;
  logic        in_acc;
  logic        in_resp;
  logic [31:0] ext;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign req = bus.mem_read | bus.mem_write;
  assign chk = check_access(bus.mem_read, bus.mem_write,
                            bus.func3, bus.address[1:0]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          f3_d    = bus.func3;
          addr_d  = bus.address;
          wd_d    = bus.write_data;
          we_d    = bus.mem_write;
          cnt_d   = '0;
          rdata_d = '0;
          cause_d = chk;
          state_d = (chk == CAUSE_NONE) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        // ack wins over a timeout landing in the same cycle
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = wd_q;
    if (we_q) begin
      unique case (1'b1)
        f3_q == SB: begin
          be    = 4'b0001 << addr_q[1:0];
          wdata = {4{wd_q[7:0]}};
        end
        f3_q == SH: begin
          be    = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata = {2{wd_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align_extend u_lae (
    .rdata_i (rdata_q),
    .addr_i  (addr_q[1:0]),
    .func3_i (f3_q),
    .data_o  (ext)
  );

  assign in_acc  = (state_q == ACCESS);
  assign in_resp = (state_q == RESP);

  assign bus.busy = (state_q == IDLE) ? req : in_acc;
  assign bus.done = in_resp;
  assign bus.fault = in_resp && (cause_q != CAUSE_NONE);
  assign bus.fault_cause = in_resp ? cause_q : CAUSE_NONE;
  assign bus.load_data =
    (in_resp && !we_q && cause_q == CAUSE_NONE) ? ext : '0;

  assign bus.mem_req   = in_acc;
  assign bus.mem_we    = in_acc & we_q;
  assign bus.mem_addr  = in_acc ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_be    = in_acc ? be : '0;
  assign bus.mem_wdata = in_acc ? wdata : '0;

endmodule

// File: tb/tb_data_mem_access_controller.sv
// Directed bench for data_mem_access_controller with queued
// expectations checked by independent response/memory monitors.
module tb_data_mem_access_controller;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] ld;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  data_mem_access_controller_if bus();

  data_mem_access_controller #(.TIMEOUT(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  rsp_t rq[$];
  mem_t mq[$];
  int ack_delay = 0;
  logic [31:0] ack_rdata = '0;
  int rcnt = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory model: ack in the ack_delay-th cycle of mem_req
  always @(negedge CLK) begin
    if (bus.mem_req) begin
      rcnt++;
      if (ack_delay != 0 && rcnt == ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ack_rdata;
      end else begin
        bus.mem_ack = 1'b0;
      end
    end else begin
      rcnt = 0;
      bus.mem_ack = 1'b0;
    end
  end

  // response monitor
  always @(negedge CLK) begin
    if (bus.done) begin
      if (rq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = rq.pop_front();
        chk("fault", 32'(bus.fault), 32'(e.cause != 2'b00));
        chk("fault_cause", 32'(bus.fault_cause), 32'(e.cause));
        chk("load_data", bus.load_data, e.ld);
      end
    end
  end

  // memory request monitor: checks the first cycle of each request
  always @(negedge CLK) begin
    if (bus.mem_req && !req_prev) begin
      if (mq.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        mem_t m;
        m = mq.pop_front();
        chk("mem_addr", bus.mem_addr, m.addr);
        chk("mem_be", 32'(bus.mem_be), 32'(m.be));
        chk("mem_wdata", bus.mem_wdata, m.wdata);
        chk("mem_we", 32'(bus.mem_we), 32'(m.we));
      end
    end
    req_prev = bus.mem_req;
  end

  task automatic run(
    input string       nm,
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          k,
    input logic [31:0] rdat,
    input logic [1:0]  ecause,
    input logic [31:0] eld,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input int          elat
  );
    int busy_c;
    int req_c;
    int lat;
    int ereq;
    rsp_t r;
    mem_t m;
    @(posedge CLK);
    #1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.func3      = f3;
    bus.address    = a;
    bus.write_data = wd;
    ack_delay = k;
    ack_rdata = rdat;
    r.cause = ecause;
    r.ld    = eld;
    rq.push_back(r);
    ereq = 0;
    if (ecause == 2'b00 || ecause == 2'b11) begin
      m.addr  = {a[31:2], 2'b00};
      m.be    = ebe;
      m.wdata = ewd;
      m.we    = wr;
      mq.push_back(m);
      ereq = elat - 1;
    end
    busy_c = 0;
    req_c  = 0;
    lat    = 0;
    @(negedge CLK);
    if (bus.busy) busy_c++;
    @(posedge CLK);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.func3     = 3'b111;
    bus.address   = 32'hFFFF_FFFF;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      if (bus.busy) busy_c++;
      if (bus.mem_req) req_c++;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_busy_cycles"}, 32'(busy_c), 32'(elat));
    chk({nm, "_req_cycles"}, 32'(req_c), 32'(ereq));
  endtask

  initial begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.func3      = 3'b000;
    bus.address    = '0;
    bus.write_data = '0;
    bus.mem_rdata  = '0;
    bus.mem_ack    = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_load_data", bus.load_data, 32'd0);
    bus.mem_read = 1'b1;
    #1;
    chk("rst_busy_follows", 32'(bus.busy), 32'd1);
    bus.mem_read = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    run("lw", 1, 0, 3'b010, 32'h100, 0, 3, 32'hDEADBEEF,
        2'b00, 32'hDEADBEEF, 4'hF, 0, 4);
    run("lb", 1, 0, 3'b000, 32'h103, 0, 1, 32'h80123456,
        2'b00, 32'hFFFFFF80, 4'hF, 0, 2);
    run("lbu", 1, 0, 3'b100, 32'h103, 0, 2, 32'h80123456,
        2'b00, 32'h00000080, 4'hF, 0, 3);
    run("lhu", 1, 0, 3'b101, 32'h102, 0, 1, 32'h80123456,
        2'b00, 32'h00008012, 4'hF, 0, 2);
    run("lh", 1, 0, 3'b001, 32'h102, 0, 1, 32'h80123456,
        2'b00, 32'hFFFF8012, 4'hF, 0, 2);
    run("lb1", 1, 0, 3'b000, 32'h101, 0, 1, 32'h80123456,
        2'b00, 32'h00000034, 4'hF, 0, 2);
    run("sh", 0, 1, 3'b001, 32'h206, 32'h0000ABCD, 2, 0,
        2'b00, 0, 4'b1100, 32'hABCDABCD, 3);
    run("sb", 0, 1, 3'b000, 32'h201, 32'h12345678, 1, 0,
        2'b00, 0, 4'b0010, 32'h78787878, 2);
    run("lw_mis", 1, 0, 3'b010, 32'h102, 0, 1, 0,
        2'b01, 0, 4'hF, 0, 1);
    run("ld_f3_011", 1, 0, 3'b011, 32'h100, 0, 1, 0,
        2'b10, 0, 4'hF, 0, 1);
    run("st_f3_100", 0, 1, 3'b100, 32'h200, 0, 1, 0,
        2'b10, 0, 4'hF, 0, 1);
    run("rd_and_wr", 1, 1, 3'b010, 32'h200, 0, 1, 0,
        2'b10, 0, 4'hF, 0, 1);
    run("ill_over_mis", 1, 0, 3'b110, 32'h101, 0, 1, 0,
        2'b10, 0, 4'hF, 0, 1);
    run("sw_mis", 0, 1, 3'b010, 32'h203, 0, 1, 0,
        2'b01, 0, 4'hF, 0, 1);
    run("lhu_mis", 1, 0, 3'b101, 32'h103, 0, 1, 0,
        2'b01, 0, 4'hF, 0, 1);
    run("timeout", 1, 0, 3'b010, 32'h300, 0, 0, 0,
        2'b11, 0, 4'hF, 0, 5);
    run("ack_at_limit", 1, 0, 3'b010, 32'h300, 0, 4,
        32'h01020304, 2'b00, 32'h01020304, 4'hF, 0, 5);

    // reset in the middle of an access: no done may follow
    begin
      mem_t m;
      @(posedge CLK);
      #1;
      bus.mem_read = 1'b1;
      bus.func3    = 3'b010;
      bus.address  = 32'h500;
      ack_delay    = 0;
      m.addr  = 32'h500;
      m.be    = 4'hF;
      m.wdata = 32'h0;
      m.we    = 1'b0;
      mq.push_back(m);
      bus.write_data = 32'h0;
      @(posedge CLK);
      #1;
      bus.mem_read = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      RESET = 1'b0;
      repeat (3) @(posedge CLK);
    end

    run("sw_after_rst", 0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 1,
        0, 2'b00, 0, 4'hF, 32'hCAFEF00D, 2);

    repeat (3) @(posedge CLK);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
